blake2s_round_ctrl: RTL and testbench
=====================================

# blake2s_round_ctrl

Sequencing controller for the BLAKE2s compression datapath. It accepts per-message `init` and per-block `next` commands and drives the message-word selector (load, round, mode). It also drives the working-vector / G-function array (init, step enable) and the chaining-value update (h_init, h_update). It maintains the 64-bit byte counter `t` and the final-block flag `f0` consumed by the v-initialisation logic.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: G rounds per block; legal range 1..10, bounded by the 20-entry SIGMA index space of {round, mode}.

Ports:
- `clk`  in  1  clock; all logic on posedge
- `reset_n`  in  1  reset, synchronous, active-low
- `init`  in  1  start new message; accepted only when `ready`
- `next`  in  1  compress the block currently on the message bus; accepted only when `ready`
- `final_block`  in  1  sampled with accepted `next`; block is the last of the message
- `blocklen`  in  7  valid bytes in block, sampled with accepted `next`; values 65..127 saturate to 64
- `ready`  out  1  controller idle, command accepted this cycle if asserted
- `digest_valid`  out  1  chaining value holds the final digest
- `m_load`  out  1  one-cycle strobe: message selector captures the 512-bit block
- `round`  out  4  round index to the message selector; 0 outside ROUND
- `mode`  out  1  0 = column step, 1 = diagonal step; 0 outside ROUND
- `v_init`  out  1  one-cycle strobe: load v[0..15] from h, IV, t, f0
- `g_en`  out  1  G array performs one step this cycle
- `h_init`  out  1  one-cycle strobe: h <= IV xor parameter block
- `h_update`  out  1  one-cycle strobe: h <= h xor v[0..7] xor v[8..15]
- `t`  out  64  byte counter, including the current block
- `f0`  out  1  final-block flag for the current block

## Operation
- States: IDLE, HINIT, VINIT, ROUND, FINISH. All strobes are decoded from the state register only, so there are no input-to-output combinational paths.
- IDLE: `ready`=1.
  - `init` goes to HINIT.
  - `next` alone goes to VINIT.
  - `init` and `next` high together: `init` wins and `next` is dropped.
  - Commands while `ready`=0 are ignored (no queueing).
- HINIT (1 cycle): `h_init`=1; `t`<=0, `f0`<=0, `digest_valid`<=0; then IDLE.
- On `next` acceptance (IDLE edge): `t` <= `t` + sat64(`blocklen`) modulo 2^64; `f0` <= `final_block`; `digest_valid` <= 0.
- VINIT (1 cycle): `m_load`=1, `v_init`=1; step counter k<=0; then ROUND.
- ROUND (2*`NUM_ROUNDS` cycles):
  - `g_en`=1, `round`=k>>1, `mode`=k[0], so {round,mode}=k.
  - k increments each cycle.
  - Leave for FINISH after k = 2*`NUM_ROUNDS`-1.
- FINISH (1 cycle): `h_update`=1; `digest_valid` <= `f0`; then IDLE.
- `next` without a prior `init` is legal: it operates on whatever h holds. No error flag.
- Arithmetic: k is 5 bits; `t` add is 64-bit unsigned with silent wrap.

## Timing
- Reset, taking effect at the clock edge with `reset_n`=0:
  - state IDLE, k=0, `t`=0, `f0`=0, `digest_valid`=0.
  - Hence from the next cycle `ready`=1 and all strobes, `round` and `mode` are 0.
- Reset in any state, including mid-ROUND, aborts immediately. No `h_update` is issued.
- `next` sampled at edge T gives:
  - VINIT during T+1.
  - ROUND during T+2..T+1+2N.
  - FINISH at T+2+2N.
  - IDLE, `ready`=1 and updated `digest_valid` at T+3+2N.
  - For N=10 the block latency is 23 cycles, with a new `next` accepted earliest at T+23.
- `init` sampled at T gives `h_init` at T+1 and `ready` at T+2.
- `m_load` in VINIT guarantees the selector words are valid from the first ROUND cycle.
- `t`/`f0` are stable from T+1 until the next accepted `next` or `init`.

## Structure
- `blake2s_pkg`:
  - state enum.
  - `BLAKE2S_BLOCK_BYTES`=64.
  - `BLAKE2S_MAX_ROUNDS`=10.
  - `BLAKE2S_CNT_W`=64.
- Optional sub-module `blake2s_t_counter`: 64-bit saturating-input byte counter with clear/add ports. Otherwise the block is a single FSM plus counters.

## Test plan
- Reset: hold `reset_n`=0 two cycles mid-traffic -> `ready`=1, `t`=0, `f0`=0, `digest_valid`=0, all strobes/`round`/`mode`=0 on the first cycle after release.
- Single final block, N=10: `init` then `next`, `blocklen`=64, `final_block`=1 at T -> `m_load`/`v_init` at T+1; `g_en` T+2..T+21 with {round,mode} = 0,1,…,19; `h_update` at T+22; `ready`=1, `digest_valid`=1, `t`=64, `f0`=1 at T+23.
- Two blocks: `next`(64, final 0) then `next`(3, final 1) -> after the first block `t`=64, `f0`=0, `digest_valid`=0; after the second `t`=67, `f0`=1, `digest_valid`=1.
- Command filtering:
  - `next` pulsed at every cycle of ROUND -> ignored; `t` unchanged.
  - `init`+`next` together in IDLE -> only `h_init`; `t`=0.
  - `blocklen`=100 -> `t` advances by 64.
- Abort: `reset_n`=0 at ROUND k=10 -> next cycle IDLE, no `h_update` ever issued for that block, `t`=0.
- Parameter: instantiate N=1 -> exactly 2 `g_en` cycles ({0,0},{0,1}); `ready` returns 5 cycles after `next`.

Source files
------------

// File: rtl/blake2s_pkg.sv
// Shared types and constants for the BLAKE2s compression sequencing logic.
package blake2s_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HINIT,
        ST_VINIT,
        ST_ROUND,
        ST_FINISH
    } state_e;

    localparam int BLAKE2S_BLOCK_BYTES = 64;
    localparam int BLAKE2S_MAX_ROUNDS  = 10;
    localparam int BLAKE2S_CNT_W       = 64;

    // A block never contributes more than 64 bytes to the counter.
    function automatic logic [6:0] sat_blocklen(input logic [6:0] bl);
        return (bl > 7'(BLAKE2S_BLOCK_BYTES)) ? 7'(BLAKE2S_BLOCK_BYTES) : bl;
    endfunction

endpackage

// File: rtl/blake2s_round_ctrl_if.sv
// Command and datapath-control bundle of the BLAKE2s round controller.
interface blake2s_round_ctrl_if;
    import blake2s_pkg::*;

    logic                     init;
    logic                     next;
    logic                     final_block;
    logic [6:0]               blocklen;
    logic                     ready;
    logic                     digest_valid;
    logic                     m_load;
    logic [3:0]               round;
    logic                     mode;
    logic                     v_init;
    logic                     g_en;
    logic                     h_init;
    logic                     h_update;
    logic [BLAKE2S_CNT_W-1:0] t;
    logic                     f0;

    modport slave (
        input  init, next, final_block, blocklen,
        output ready, digest_valid, m_load, round, mode, v_init, g_en,
               h_init, h_update, t, f0
    );

    modport master (
        output init, next, final_block, blocklen,
        input  ready, digest_valid, m_load, round, mode, v_init, g_en,
               h_init, h_update, t, f0
    );

endinterface

// File: rtl/blake2s_t_counter.sv
// 64-bit BLAKE2s byte counter; each add contributes the saturated block length.
module blake2s_t_counter
    import blake2s_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr_i,
    input  logic                     add_i,
    input  logic [6:0]               blocklen_i,
    output logic [BLAKE2S_CNT_W-1:0] t_o
);

    logic [BLAKE2S_CNT_W-1:0] t_q, t_d;

    always_comb begin
        t_d = t_q;
        if (clr_i) begin
            t_d = '0;
        end else if (add_i) begin
            t_d = t_q + BLAKE2S_CNT_W'(sat_blocklen(blocklen_i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    assign t_o = t_q;

endmodule

// File: rtl/blake2s_round_ctrl.sv
// BLAKE2s compression sequencer: IDLE -> (HINIT | VINIT -> ROUND x 2N -> FINISH) -> IDLE.
module blake2s_round_ctrl
    import blake2s_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    blake2s_round_ctrl_if.slave  bus
);

    localparam logic [4:0] K_LAST = 5'(2 * NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [4:0] k_q, k_d;
    logic       f0_q, f0_d;
    logic       dv_q, dv_d;
    logic       t_clr, t_add;

    logic       ready_s, m_load_s, v_init_s, g_en_s, h_init_s, h_update_s, mode_s;
    logic [3:0] round_s;

    // Strobes depend on state_q only; inputs steer the next state alone.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        f0_d       = f0_q;
        dv_d       = dv_q;
        t_clr      = 1'b0;
        t_add      = 1'b0;
        ready_s    = 1'b0;
        m_load_s   = 1'b0;
        v_init_s   = 1'b0;
        g_en_s     = 1'b0;
        h_init_s   = 1'b0;
        h_update_s = 1'b0;
        round_s    = 4'd0;
        mode_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (bus.init) begin
                    state_d = ST_HINIT;
                end else if (bus.next) begin
                    state_d = ST_VINIT;
                    t_add   = 1'b1;
                    f0_d    = bus.final_block;
                    dv_d    = 1'b0;
                end
            end
            ST_HINIT: begin
                h_init_s = 1'b1;
                t_clr    = 1'b1;
                f0_d     = 1'b0;
                dv_d     = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_VINIT: begin
                m_load_s = 1'b1;
                v_init_s = 1'b1;
                k_d      = 5'd0;
                state_d  = ST_ROUND;
            end
            ST_ROUND: begin
                g_en_s  = 1'b1;
                round_s = k_q[4:1];
                mode_s  = k_q[0];
                k_d     = k_q + 5'd1;
                if (k_q == K_LAST) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                h_update_s = 1'b1;
                dv_d       = f0_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= 5'd0;
            f0_q    <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            f0_q    <= f0_d;
            dv_q    <= dv_d;
        end
    end

    blake2s_t_counter u_t_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (t_clr),
        .add_i      (t_add),
        .blocklen_i (bus.blocklen),
        .t_o        (bus.t)
    );

    assign bus.ready        = ready_s;
    assign bus.digest_valid = dv_q;
    assign bus.m_load       = m_load_s;
    assign bus.round        = round_s;
    assign bus.mode         = mode_s;
    assign bus.v_init       = v_init_s;
    assign bus.g_en         = g_en_s;
    assign bus.h_init       = h_init_s;
    assign bus.h_update     = h_update_s;
    assign bus.f0           = f0_q;

endmodule

// File: tb/tb_blake2s_round_ctrl.sv
// Bench for blake2s_round_ctrl: N=10 and N=1 instances against a cycle-schedule reference model.
module tb_blake2s_round_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    blake2s_round_ctrl_if bus10 ();
    blake2s_round_ctrl_if bus1 ();

    blake2s_round_ctrl #(.NUM_ROUNDS(10)) dut10 (.clk(clk), .reset_n(reset_n), .bus(bus10));
    blake2s_round_ctrl #(.NUM_ROUNDS(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(bus1));

    int compared = 0;
    int mismatched = 0;
    int nr [2] = '{10, 1};

    // Reference model: message-level state per instance
    logic [63:0] ref_t  [2];
    logic        ref_f0 [2];
    logic        ref_dv [2];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ready, m_load, v_init, g_en, h_init, h_update, round, mode}
    function automatic logic [10:0] strobes(int sel);
        if (sel == 0)
            return {bus10.ready, bus10.m_load, bus10.v_init, bus10.g_en, bus10.h_init,
                    bus10.h_update, bus10.round, bus10.mode};
        return {bus1.ready, bus1.m_load, bus1.v_init, bus1.g_en, bus1.h_init,
                bus1.h_update, bus1.round, bus1.mode};
    endfunction

    function automatic logic [63:0] get_t(int sel);
        return (sel == 0) ? bus10.t : bus1.t;
    endfunction

    function automatic logic [1:0] get_f0dv(int sel);
        return (sel == 0) ? {bus10.f0, bus10.digest_valid} : {bus1.f0, bus1.digest_valid};
    endfunction

    // Expected strobes c cycles after a `next` was accepted, from the timing rules
    function automatic logic [10:0] exp_block(int c, int n);
        logic rdy, ml, vi, g, hu;
        logic [3:0] rd;
        logic md;
        int kk;
        rdy = 0; ml = 0; vi = 0; g = 0; hu = 0; rd = 0; md = 0;
        if (c == 1) begin
            ml = 1; vi = 1;
        end else if (c >= 2 && c <= 2 * n + 1) begin
            g  = 1;
            kk = c - 2;
            rd = 4'(kk / 2);
            md = (kk % 2) == 1;
        end else if (c == 2 * n + 2) begin
            hu = 1;
        end else begin
            rdy = 1;
        end
        return {rdy, ml, vi, g, 1'b0, hu, rd, md};
    endfunction

    localparam logic [10:0] IDLE_VEC  = 11'b100_0000_0000;
    localparam logic [10:0] HINIT_VEC = 11'b000_0100_0000;

    task automatic drive(int sel, logic i, logic n, logic [6:0] bl, logic fb);
        if (sel == 0) begin
            bus10.init = i; bus10.next = n; bus10.blocklen = bl; bus10.final_block = fb;
        end else begin
            bus1.init = i; bus1.next = n; bus1.blocklen = bl; bus1.final_block = fb;
        end
    endtask

    task automatic check_ctx(int sel, string tag);
        chk({tag, "_t"}, get_t(sel), ref_t[sel]);
        chk({tag, "_f0dv"}, 64'(get_f0dv(sel)), 64'({ref_f0[sel], ref_dv[sel]}));
    endtask

    task automatic do_reset(int hold);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            ref_t[s] = 0; ref_f0[s] = 0; ref_dv[s] = 0;
            chk($sformatf("rst%0d_strobes", s), 64'(strobes(s)), 64'(IDLE_VEC));
            check_ctx(s, $sformatf("rst%0d", s));
        end
        $display("txn reset hold=%0d", hold);
    endtask

    task automatic do_init(int sel, logic with_next);
        drive(sel, 1, with_next, 7'($urandom_range(0, 127)), 1'($urandom));
        @(negedge clk);
        drive(sel, 0, 0, 0, 0);
        chk($sformatf("init%0d_hinit", sel), 64'(strobes(sel)), 64'(HINIT_VEC));
        @(negedge clk);
        ref_t[sel] = 0; ref_f0[sel] = 0; ref_dv[sel] = 0;
        chk($sformatf("init%0d_ready", sel), 64'(strobes(sel)), 64'(IDLE_VEC));
        check_ctx(sel, $sformatf("init%0d", sel));
        $display("txn sel=%0d init with_next=%0d t=%0h", sel, with_next, get_t(sel));
    endtask

    task automatic do_next(int sel, logic [6:0] bl, logic fb, logic pester);
        int n;
        n = nr[sel];
        drive(sel, 0, 1, bl, fb);
        @(negedge clk);
        ref_t[sel]  = ref_t[sel] + ((bl > 7'd64) ? 64'd64 : 64'(bl));
        ref_f0[sel] = fb;
        ref_dv[sel] = 0;
        for (int c = 1; c <= 2 * n + 3; c++) begin
            if (c > 1) @(negedge clk);
            chk($sformatf("n%0d_c%0d", sel, c), 64'(strobes(sel)), 64'(exp_block(c, n)));
            if (c == 1) check_ctx(sel, $sformatf("n%0d_first", sel));
            if (pester && c < 2 * n + 3)
                drive(sel, 1'($urandom), 1, 7'($urandom_range(0, 127)), 1'($urandom));
            else
                drive(sel, 0, 0, 0, 0);
        end
        ref_dv[sel] = fb;
        check_ctx(sel, $sformatf("n%0d_done", sel));
        $display("txn sel=%0d next bl=%0d final=%0d pester=%0d t=%0h", sel, bl, fb, pester, get_t(sel));
    endtask

    // Reset asserted during ROUND step k of instance 0
    task automatic do_abort(int k, int hold);
        int seen;
        seen = 0;
        drive(0, 0, 1, 7'd64, 1);
        for (int c = 1; c <= k + 2; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
            chk($sformatf("abort_c%0d", c), 64'(strobes(0)), 64'(exp_block(c, 10)));
        end
        do_reset(hold);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus10.h_update) seen++;
        end
        chk("abort_no_hupd", 64'(seen), 64'd0);
        check_ctx(0, "abort_after");
        $display("txn abort k=%0d hold=%0d", k, hold);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        do_reset(2);

        do_init(0, 0);
        do_next(0, 7'd64, 1'b1, 1'b0);
        do_init(0, 0);
        do_next(0, 7'd64, 1'b0, 1'b0);
        do_next(0, 7'd3, 1'b1, 1'b0);
        do_next(0, 7'd7, 1'b0, 1'b1);
        do_init(0, 1'b1);
        do_next(0, 7'd100, 1'b0, 1'b0);
        do_abort(10, 1);
        do_next(0, 7'd17, 1'b0, 1'b0);
        do_abort($urandom_range(0, 19), 2);

        do_init(1, 0);
        do_next(1, 7'd64, 1'b1, 1'b0);
        do_next(1, 7'd127, 1'b0, 1'b1);

        for (int i = 0; i < 14; i++) begin
            int sel, op;
            sel = $urandom_range(0, 1);
            op  = $urandom_range(0, 5);
            if (op == 0)
                do_init(sel, 1'b0);
            else if (op == 1)
                do_init(sel, 1'b1);
            else
                do_next(sel, 7'($urandom_range(0, 127)), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
